// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants: vectors and PCSrc codes
package mips_pkg;

   // Default vector addresses; bit31 set means kernel mode
   localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
   localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

   // PCSrc codes produced by the ID-stage decoder
   localparam logic [2:0] PCSRC_SEQ = 3'b000;
   localparam logic [2:0] PCSRC_J   = 3'b001;
   localparam logic [2:0] PCSRC_JR  = 3'b010;
   localparam logic [2:0] PCSRC_IRQ = 3'b100;
   localparam logic [2:0] PCSRC_EXC = 3'b101;

   // +4 on the low 31 bits only: wraps 7FFF_FFFC to 0 and never changes the mode bit
   function automatic logic [31:0] add4_keep_mode(input logic [31:0] a);
      return {a[31], a[30:0] + 31'd4};
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - pipeline-side signals of the PC stage
interface pc_sequencer_if;

   logic        stall;
   logic [2:0]  pc_src;
   logic [25:0] jump_target;
   logic [31:0] jr_target;
   logic [31:0] pc_id;
   logic        id_valid;
   logic        branch_taken;
   logic [31:0] branch_target;

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        irq_req;
   logic [31:0] epc;
   logic        flush_if_id;
   logic        flush_id_ex;

   // Pipeline side: drives decode/EX controls, consumes PC and strobes
   modport master (
      output stall, pc_src, jump_target, jr_target, pc_id, id_valid,
             branch_taken, branch_target,
      input  pc, pc_plus4, irq_req, epc, flush_if_id, flush_id_ex
   );

   // PC stage side
   modport slave (
      input  stall, pc_src, jump_target, jr_target, pc_id, id_valid,
             branch_taken, branch_target,
      output pc, pc_plus4, irq_req, epc, flush_if_id, flush_id_ex
   );

endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop synchroniser with asynchronous active-low clear
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous level into the clk domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC register, next-PC select, IRQ gating, EPC and flushes
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
   parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           irq_raw,
   pc_sequencer_if.slave  bus
);

   logic [31:0] pc_q;
   logic [31:0] epc_q;
   logic [31:0] pc_next;
   logic [31:0] epc_next;
   logic [31:0] pc_plus4_w;
   logic [31:0] pc_id_plus4;
   logic        irq_s;
   logic        id_redirect;

   irq_sync u_irq_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq_raw),
      .q     (irq_s)
   );

   assign pc_plus4_w  = add4_keep_mode(pc_q);
   assign pc_id_plus4 = add4_keep_mode(bus.pc_id);

   // Codes 011/110/111 fall through to sequential and do not flush
   assign id_redirect = (bus.pc_src == PCSRC_J)   || (bus.pc_src == PCSRC_JR) ||
                        (bus.pc_src == PCSRC_IRQ) || (bus.pc_src == PCSRC_EXC);

   // Next PC and EPC: EX branch beats stall, stall beats every ID redirect
   always_comb begin
      pc_next  = pc_plus4_w;
      epc_next = epc_q;
      if (bus.branch_taken) begin
         // Branches stay in the mode of the branching instruction
         pc_next = {bus.pc_id[31], bus.branch_target[30:0]};
      end else if (bus.stall) begin
         pc_next = pc_q;
      end else begin
         case (bus.pc_src)
            PCSRC_IRQ: begin
               pc_next  = IRQ_VEC;
               epc_next = bus.pc_id;
            end
            PCSRC_EXC: begin
               pc_next  = EXC_VEC;
               epc_next = pc_id_plus4;
            end
            PCSRC_J: begin
               pc_next = {bus.pc_id[31], pc_id_plus4[30:28], bus.jump_target, 2'b00};
            end
            PCSRC_JR: begin
               // User code can never raise the mode bit through a register jump
               pc_next = {bus.jr_target[31] & bus.pc_id[31], bus.jr_target[30:0]};
            end
            default: begin
               pc_next = pc_plus4_w;
            end
         endcase
      end
   end

   // PC and EPC registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q  <= RESET_VEC;
         epc_q <= 32'h0000_0000;
      end else begin
         pc_q  <= pc_next;
         epc_q <= epc_next;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pc_plus4    = pc_plus4_w;
   assign bus.epc         = epc_q;
   assign bus.irq_req     = irq_s & bus.id_valid & ~bus.pc_id[31] & ~bus.stall & ~bus.branch_taken;
   assign bus.flush_if_id = bus.branch_taken | (~bus.stall & id_redirect);
   assign bus.flush_id_ex = bus.branch_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;

   logic clk;
   logic reset;
   logic irq_raw;
   int   n_tests;
   int   n_fail;

   pc_sequencer_if bus ();

   pc_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .irq_raw (irq_raw),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        stall;
      logic [2:0]  src;
      logic [25:0] jt;
      logic [31:0] jr;
      logic [31:0] pcid;
      logic        idv;
      logic        bt;
      logic [31:0] btgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_epc;
      logic        exp_fif;
      logic        exp_fie;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic stall, logic [2:0] src, logic [25:0] jt, logic [31:0] jr,
                               logic [31:0] pcid, logic bt, logic [31:0] btgt,
                               logic [31:0] exp_pc, logic [31:0] exp_epc,
                               logic exp_fif, logic exp_fie);
      vec_t v;
      v.stall = stall; v.src = src; v.jt = jt; v.jr = jr; v.pcid = pcid; v.idv = 1'b1;
      v.bt = bt; v.btgt = btgt; v.exp_pc = exp_pc; v.exp_epc = exp_epc;
      v.exp_fif = exp_fif; v.exp_fie = exp_fie;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic [2:0] src, input logic [25:0] jt,
                        input logic [31:0] jr, input logic [31:0] pcid, input logic idv,
                        input logic bt, input logic [31:0] btgt);
      bus.stall = stall; bus.pc_src = src; bus.jump_target = jt; bus.jr_target = jr;
      bus.pc_id = pcid; bus.id_valid = idv; bus.branch_taken = bt; bus.branch_target = btgt;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      irq_raw = 1'b0;
      reset   = 1'b0;
      drive(1'b0, 3'b000, 26'h0, 32'h0, 32'h0040_0000, 1'b1, 1'b0, 32'h0);

      // Table: chained from reset state pc=8000_0000, epc=0, irq_raw low
      tbl.push_back(mk(0, 3'b000, 26'h0,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h8000_0004, 32'h0,         0, 0));
      tbl.push_back(mk(0, 3'b000, 26'h0,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h8000_0008, 32'h0,         0, 0));
      tbl.push_back(mk(0, 3'b001, 26'h0100004, 32'h0,         32'h0040_0000, 0, 32'h0,         32'h0040_0010, 32'h0,         1, 0));
      tbl.push_back(mk(0, 3'b010, 26'h0,       32'h8000_1000, 32'h0040_0020, 0, 32'h0,         32'h0000_1000, 32'h0,         1, 0));
      tbl.push_back(mk(0, 3'b010, 26'h0,       32'h8000_1000, 32'h8000_0040, 0, 32'h0,         32'h8000_1000, 32'h0,         1, 0));
      tbl.push_back(mk(0, 3'b101, 26'h0,       32'h0,         32'h0040_0300, 0, 32'h0,         32'h8000_0008, 32'h0040_0304, 1, 0));
      tbl.push_back(mk(1, 3'b101, 26'h0,       32'h0,         32'h0040_01F8, 1, 32'h0040_0200, 32'h0040_0200, 32'h0040_0304, 1, 1));
      tbl.push_back(mk(0, 3'b000, 26'h0,       32'h0,         32'h0040_0000, 1, 32'h8000_0100, 32'h0000_0100, 32'h0040_0304, 1, 1));
      tbl.push_back(mk(1, 3'b001, 26'h3,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_0100, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(1, 3'b000, 26'h0,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_0100, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(0, 3'b011, 26'h3,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_0104, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(0, 3'b110, 26'h3,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_0108, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(0, 3'b111, 26'h3,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_010C, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(0, 3'b010, 26'h0,       32'h7FFF_FFFC, 32'h0040_0000, 0, 32'h0,         32'h7FFF_FFFC, 32'h0040_0304, 1, 0));
      tbl.push_back(mk(0, 3'b000, 26'h0,       32'h0,         32'h0040_0000, 0, 32'h0,         32'h0000_0000, 32'h0040_0304, 0, 0));
      tbl.push_back(mk(0, 3'b001, 26'h0,       32'h0,         32'h8FFF_FFFC, 0, 32'h0,         32'h9000_0000, 32'h0040_0304, 1, 0));
      tbl.push_back(mk(0, 3'b100, 26'h0,       32'h0,         32'h0040_0100, 0, 32'h0,         32'h8000_0004, 32'h0040_0100, 1, 0));
      tbl.push_back(mk(0, 3'b101, 26'h0,       32'h0,         32'h7FFF_FFFC, 0, 32'h0,         32'h8000_0008, 32'h0000_0000, 1, 0));
      tbl.push_back(mk(1, 3'b100, 26'h0,       32'h0,         32'h0040_0500, 0, 32'h0,         32'h8000_0008, 32'h0000_0000, 0, 0));
      tbl.push_back(mk(0, 3'b000, 26'h0,       32'h0,         32'h0040_0500, 0, 32'h0,         32'h8000_000C, 32'h0000_0000, 0, 0));

      // Reset state
      tick();
      tick();
      chk("reset_pc",       bus.pc,       32'h8000_0000);
      chk("reset_pc_plus4", bus.pc_plus4, 32'h8000_0004);
      chk("reset_epc",      bus.epc,      32'h0);
      chk("reset_irq_req",  {31'h0, bus.irq_req}, 32'h0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].stall, tbl[i].src, tbl[i].jt, tbl[i].jr, tbl[i].pcid, tbl[i].idv,
               tbl[i].bt, tbl[i].btgt);
         #1;
         chk($sformatf("v%0d_flush_if_id", i), {31'h0, bus.flush_if_id}, {31'h0, tbl[i].exp_fif});
         chk($sformatf("v%0d_flush_id_ex", i), {31'h0, bus.flush_id_ex}, {31'h0, tbl[i].exp_fie});
         chk($sformatf("v%0d_irq_req", i),     {31'h0, bus.irq_req},     32'h0);
         tick();
         chk($sformatf("v%0d_pc", i),  bus.pc,  tbl[i].exp_pc);
         chk($sformatf("v%0d_epc", i), bus.epc, tbl[i].exp_epc);
      end

      // Jump held off by a 3-cycle stall, taken once stall drops (pc=8000_000C here)
      drive(1'b1, 3'b001, 26'h0100004, 32'h0, 32'h0040_0000, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stallj%0d_flush_if_id", k), {31'h0, bus.flush_if_id}, 32'h0);
         tick();
         chk($sformatf("stallj%0d_pc", k), bus.pc, 32'h8000_000C);
      end
      bus.stall = 1'b0;
      #1;
      chk("stallj_release_flush", {31'h0, bus.flush_if_id}, 32'h1);
      tick();
      chk("stallj_release_pc", bus.pc, 32'h0040_0010);

      // Interrupt synchroniser latency, masking and vectoring
      drive(1'b0, 3'b000, 26'h0, 32'h0, 32'h0040_0100, 1'b1, 1'b0, 32'h0);
      irq_raw = 1'b1;
      #1;
      chk("irq_edge0", {31'h0, bus.irq_req}, 32'h0);
      tick();
      chk("irq_edge1", {31'h0, bus.irq_req}, 32'h0);
      tick();
      chk("irq_edge2", {31'h0, bus.irq_req}, 32'h1);
      bus.stall = 1'b1;        #1; chk("irq_mask_stall",  {31'h0, bus.irq_req}, 32'h0);
      bus.stall = 1'b0;
      bus.branch_taken = 1'b1; #1; chk("irq_mask_branch", {31'h0, bus.irq_req}, 32'h0);
      bus.branch_taken = 1'b0;
      bus.id_valid = 1'b0;     #1; chk("irq_mask_bubble", {31'h0, bus.irq_req}, 32'h0);
      bus.id_valid = 1'b1;
      bus.pc_id = 32'h8000_0040; #1; chk("irq_mask_kernel", {31'h0, bus.irq_req}, 32'h0);
      bus.pc_id = 32'h0040_0100;
      bus.pc_src = 3'b100;
      #1;
      chk("irq_take_req", {31'h0, bus.irq_req}, 32'h1);
      tick();
      chk("irq_take_pc",  bus.pc,  32'h8000_0004);
      chk("irq_take_epc", bus.epc, 32'h0040_0100);
      irq_raw = 1'b0;

      // Asynchronous reset in mid-run
      drive(1'b0, 3'b001, 26'h0100004, 32'h0, 32'h0040_0000, 1'b1, 1'b0, 32'h0);
      tick();
      chk("mid_pre_pc", bus.pc, 32'h0040_0010);
      bus.pc_src = 3'b000;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_async_pc",     bus.pc,       32'h8000_0000);
      chk("mid_async_plus4",  bus.pc_plus4, 32'h8000_0004);
      chk("mid_async_epc",    bus.epc,      32'h0);
      tick();
      reset = 1'b1;
      tick();
      chk("mid_rel_pc1", bus.pc, 32'h8000_0004);
      tick();
      chk("mid_rel_pc2", bus.pc, 32'h8000_0008);

      // irq_raw held through reset shows up two edges after release
      reset   = 1'b0;
      irq_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("irqrst_held%0d", k), {31'h0, bus.irq_req}, 32'h0);
      end
      reset = 1'b1;
      tick();
      chk("irqrst_rel1", {31'h0, bus.irq_req}, 32'h0);
      tick();
      chk("irqrst_rel2", {31'h0, bus.irq_req}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the five-stage MIPS pipeline. It holds the fetch PC and selects the next PC from the ID-stage decoder's 3-bit PCSrc code, EX-stage branch resolution and hazard stall. It synchronises and masks the external interrupt line, producing the `IRQ` input the decoder consumes, and captures the exception return address. It also drives the IF/ID and ID/EX flush strobes.

## Interface
- `RESET_VEC`, 32'h8000_0000, PC after reset (kernel mode)
- `IRQ_VEC`, 32'h8000_0004, interrupt handler entry
- `EXC_VEC`, 32'h8000_0008, illegal-instruction handler entry
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; asserted low clears all state immediately
- `irq_raw` in 1: external interrupt, asynchronous, level
- `stall` in 1: load-use hazard; hold PC and IF/ID
- `pc_src` in 3: decoder PCSrc: 000 seq, 001 jump, 010 jr, 100 irq, 101 exception
- `jump_target` in 26: ID instruction [25:0]
- `jr_target` in 32: forwarded rs value
- `pc_id` in 32: PC of instruction in ID
- `id_valid` in 1: ID holds a real instruction (0 = bubble)
- `branch_taken` in 1: EX-stage branch resolved taken
- `branch_target` in 32: EX-stage branch target
- `pc` out 32: fetch address (registered)
- `pc_plus4` out 32: {pc[31], pc[30:0]+4}
- `irq_req` out 1: to decoder `IRQ`
- `epc` out 32: last captured return address (registered)
- `flush_if_id` out 1: clear IF/ID at next edge
- `flush_id_ex` out 1: clear ID/EX at next edge

## Operation
- Next-PC priority, highest first:
  - `branch_taken` → `branch_target`, with bit31 forced to `pc_id[31]`.
  - `stall` → hold `pc`.
  - `pc_src` 100 → `IRQ_VEC`.
  - 101 → `EXC_VEC`.
  - 001 → {pc_id[31], pc_id[30:28]+carry-free from pc_id+4, jump_target, 2'b00}. Precisely: {pc_id[31], (pc_id+4)[30:28], jump_target, 00}.
  - 010 → {jr_target[31] & pc_id[31], jr_target[30:0]}.
  - Otherwise `pc_plus4`.
- Codes 011, 110 and 111 behave as 000.
- Supervisor bit: `pc[31]`=1 means kernel. It is never set except via reset or vectors. User code cannot enter kernel through `jr`. The +4 add is 31-bit and wraps 7FFF_FFFC→0000_0000 without touching bit31.
- IRQ path: two-flop synchroniser on `irq_raw`, giving `irq_s`.
  - `irq_req` = `irq_s` & `id_valid` & ~`pc_id[31]` & ~`stall` & ~`branch_taken`.
  - Interrupts are masked in kernel mode, never taken on bubbles, and deferred while stalled or while ID is being squashed.
- EPC capture, applied when not overridden by `branch_taken` or `stall`:
  - On `pc_src`=100, `epc` ← `pc_id`; the interrupted instruction is re-executed.
  - On 101, `epc` ← `pc_id`+4.
  - Otherwise `epc` holds.
- Flush:
  - `flush_if_id` = `branch_taken` | (~`stall` & `pc_src`∈{001,010,100,101}).
  - `flush_id_ex` = `branch_taken`.
- Simultaneous events:
  - `branch_taken` with any `pc_src` or `stall`: branch wins, and neither `epc` nor `irq_req` takes effect.
  - `stall` with `pc_src`≠000: the redirect waits until the stall drops.

## Timing
- `pc` updates one edge after the inputs select it. The redirect penalty is 1 bubble for ID redirects and 2 for EX branches.
- `irq_req` is asserted no earlier than 2 edges after `irq_raw` rises. It is combinational from `irq_s` and the ID inputs.
- `pc_plus4`, `irq_req` and both flush outputs are combinational, with no registered-output latency.
- Reset (low), asynchronously: `pc`=`RESET_VEC`, `epc`=0, sync flops=0. Hence `pc_plus4`=8000_0004 and `irq_req`=0. Flushes follow their inputs.
- Reset release mid-stream: first fetch is from `RESET_VEC` on the first edge after `reset` goes high. An `irq_raw` held through reset appears 2 edges after release.

## Structure
- Shared package `mips_pkg`: `RESET_VEC`/`IRQ_VEC`/`EXC_VEC` defaults and PCSrc code constants (`PCSRC_SEQ`, `PCSRC_J`, `PCSRC_JR`, `PCSRC_IRQ`, `PCSRC_EXC`). The decoder uses the same constants.
- One sub-module `irq_sync`: 2-flop synchroniser with async active-low clear.

## Test plan
- Reset low mid-run with `pc`=0040_0010 → `pc`=8000_0000 immediately. After release with `pc_src`=000: 8000_0004, then 8000_0008.
- User `pc_id`=0040_0000, `pc_src`=001, `jump_target`=26'h0100004 → next `pc`=0040_0010. `flush_if_id`=1 for one cycle.
- `pc_src`=010, `pc_id`=0040_0020, `jr_target`=8000_1000 → `pc`=0000_1000 (kernel entry blocked). With `pc_id`=8000_0040 → `pc`=8000_1000.
- `irq_raw` rises, `pc_id`=0040_0100 valid → `irq_req`=1 on the 2nd edge. With `pc_src`=100 → `pc`=8000_0004, `epc`=0040_0100. With `pc_id[31]`=1 → `irq_req` stays 0.
- `branch_taken`=1, `branch_target`=0040_0200, same cycle `pc_src`=101 and `stall`=1 → `pc`=0040_0200, both flushes=1, `epc` unchanged.
- `stall`=1 for 3 cycles with `pc_src`=001 → `pc` constant and `flush_if_id`=0. Jump taken on the first cycle after `stall` drops.
